fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the word-addressed, combinationally read instruction memory (instruction index = address >> 2).
- Owns the program counter and drives the memory address.
- Registers the returned instruction word and its PC into a fetch output register for decode.
- Supports stall, branch/jump redirect with flush, fault detection with a sticky fault state, and a fetch counter.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/fetch_next_pc.sv | 64 ++++++
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pkg : shared widths, NOP encoding and fetch-stage enumerations
// Rev 1.0
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    FAULT = 2'b10
  } fetch_state_t;

  typedef enum logic [1:0] {
    FF_NONE     = 2'b00,
    FF_MISALIGN = 2'b01,
    FF_RANGE    = 2'b10
  } fetch_fault_t;

endpackage
`default_nettype wire

// File: rtl/fetch_next_pc.sv
`default_nettype none
// ============================================================================
// fetch_next_pc : combinational next-PC / next-state / fault selection
// Rev 1.0
// ============================================================================
module fetch_next_pc
  import riscv_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 32
) (
  input  fetch_state_t    state,
  input  logic [XLEN-1:0] pc,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output fetch_state_t    next_state,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            capture,
  output logic            flush,
  output logic            set_fault,
  output fetch_fault_t    new_cause
);

  localparam logic [XLEN-1:0] c_PC_LIMIT = XLEN'(IMEM_DEPTH * 4);

  assign pc_plus4 = pc + 32'd4;

  // Redirect beats stall; stall beats the range check so a stalled
  // out-of-range PC only faults once it is actually fetched.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    capture    = 1'b0;
    flush      = 1'b0;
    set_fault  = 1'b0;
    new_cause  = FF_NONE;
    case (state)
      BOOT: next_state = RUN;
      RUN: begin
        if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
          next_state = FAULT;
          set_fault  = 1'b1;
          new_cause  = FF_MISALIGN;
        end else if (redirect_valid) begin
          next_pc = redirect_target;
          flush   = 1'b1;
        end else if (stall) begin
          next_pc = pc;
        end else if (pc >= c_PC_LIMIT) begin
          next_state = FAULT;
          set_fault  = 1'b1;
          new_cause  = FF_RANGE;
        end else begin
          next_pc = pc_plus4;
          capture = 1'b1;
        end
      end
      default: next_state = state;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC ownership, fetch output register, sticky fault, fetch count
// Rev 1.0
// ============================================================================
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic            instr_valid,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic [31:0]     fetch_count
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc_out;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_valid;
  logic            r_fault;
  fetch_fault_t    r_cause;
  logic [31:0]     r_count;

  fetch_state_t    w_next_state;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_capture;
  logic            w_flush;
  logic            w_set_fault;
  fetch_fault_t    w_new_cause;

  fetch_next_pc #(
    .IMEM_DEPTH(IMEM_DEPTH)
  ) u_next_pc (
    .state          (r_state),
    .pc             (r_pc),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .next_state     (w_next_state),
    .next_pc        (w_next_pc),
    .pc_plus4       (w_pc_plus4),
    .capture        (w_capture),
    .flush          (w_flush),
    .set_fault      (w_set_fault),
    .new_cause      (w_new_cause)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_pc_out   <= 32'd0;
      r_pc_plus4 <= 32'd4;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
      r_cause    <= FF_NONE;
      r_count    <= 32'd0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      if (w_capture) begin
        r_instr    <= imem_data;
        r_pc_out   <= r_pc;
        r_pc_plus4 <= w_pc_plus4;
        r_valid    <= 1'b1;
        r_count    <= r_count + 32'd1;
      end else if (w_flush) begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end else if (w_set_fault) begin
        r_valid <= 1'b0;
        r_fault <= 1'b1;
        r_cause <= w_new_cause;
      end
    end
  end

  assign imem_addr    = r_pc;
  assign instr_out    = r_instr;
  assign pc_out       = r_pc_out;
  assign pc_plus4_out = r_pc_plus4;
  assign instr_valid  = r_valid;
  assign fault        = r_fault;
  assign fault_cause  = r_cause;
  assign fetch_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed vector table plus hand-written fault/reset sequences
// Rev 1.0
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic        instr_valid;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:31];

  always #5 clk = ~clk;

  assign imem_data = (imem_addr < 32'd128) ? mem[imem_addr[6:2]] : 32'hDEAD_BEEF;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_DEPTH(32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .pc_plus4_out   (pc_plus4_out),
    .instr_valid    (instr_valid),
    .fault          (fault),
    .fault_cause    (fault_cause),
    .fetch_count    (fetch_count)
  );

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] cnt;
    logic        flt;
    logic [1:0]  cause;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic valid, input logic [31:0] instr,
                           input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] cnt,
                           input logic flt, input logic [1:0] cause);
    chk({tag, " valid"},  {31'd0, instr_valid}, {31'd0, valid});
    chk({tag, " instr"},  instr_out, instr);
    chk({tag, " pc_out"}, pc_out, pc);
    chk({tag, " pc+4"},   pc_plus4_out, pc + 32'd4);
    chk({tag, " addr"},   imem_addr, addr);
    chk({tag, " count"},  fetch_count, cnt);
    chk({tag, " fault"},  {31'd0, fault}, {31'd0, flt});
    chk({tag, " cause"},  {30'd0, fault_cause}, {30'd0, cause});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 | 32'(i);

    //          stall rv tgt           valid instr          pc        addr      cnt flt cause
    vecs[0]  = '{0, 0, 32'h0,  0, 32'h0000_0013, 32'h00, 32'h00, 0, 0, 2'd0};
    vecs[1]  = '{0, 0, 32'h0,  1, 32'hC0DE_0000, 32'h00, 32'h04, 1, 0, 2'd0};
    vecs[2]  = '{0, 0, 32'h0,  1, 32'hC0DE_0001, 32'h04, 32'h08, 2, 0, 2'd0};
    vecs[3]  = '{0, 0, 32'h0,  1, 32'hC0DE_0002, 32'h08, 32'h0C, 3, 0, 2'd0};
    vecs[4]  = '{1, 0, 32'h0,  1, 32'hC0DE_0002, 32'h08, 32'h0C, 3, 0, 2'd0};
    vecs[5]  = '{1, 0, 32'h0,  1, 32'hC0DE_0002, 32'h08, 32'h0C, 3, 0, 2'd0};
    vecs[6]  = '{1, 0, 32'h0,  1, 32'hC0DE_0002, 32'h08, 32'h0C, 3, 0, 2'd0};
    vecs[7]  = '{0, 0, 32'h0,  1, 32'hC0DE_0003, 32'h0C, 32'h10, 4, 0, 2'd0};
    vecs[8]  = '{0, 0, 32'h0,  1, 32'hC0DE_0004, 32'h10, 32'h14, 5, 0, 2'd0};
    vecs[9]  = '{0, 1, 32'h40, 0, 32'h0000_0013, 32'h10, 32'h40, 5, 0, 2'd0};
    vecs[10] = '{0, 0, 32'h0,  1, 32'hC0DE_0010, 32'h40, 32'h44, 6, 0, 2'd0};
    vecs[11] = '{1, 1, 32'h20, 0, 32'h0000_0013, 32'h40, 32'h20, 6, 0, 2'd0};
    vecs[12] = '{0, 0, 32'h0,  1, 32'hC0DE_0008, 32'h20, 32'h24, 7, 0, 2'd0};
    vecs[13] = '{0, 1, 32'h22, 0, 32'hC0DE_0008, 32'h20, 32'h24, 7, 1, 2'd1};
    vecs[14] = '{0, 1, 32'h40, 0, 32'hC0DE_0008, 32'h20, 32'h24, 7, 1, 2'd1};
    vecs[15] = '{1, 0, 32'h0,  0, 32'hC0DE_0008, 32'h20, 32'h24, 7, 1, 2'd1};
    vecs[16] = '{0, 1, 32'h23, 0, 32'hC0DE_0008, 32'h20, 32'h24, 7, 1, 2'd1};

    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'd0;
    step();
    step();
    chk_state("reset", 0, 32'h0000_0013, 32'h0, 32'h0, 32'd0, 0, 2'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      stall           = vecs[i].stall;
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].tgt;
      step();
      chk_state($sformatf("v%0d", i), vecs[i].valid, vecs[i].instr, vecs[i].pc,
                vecs[i].addr, vecs[i].cnt, vecs[i].flt, vecs[i].cause);
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'd0;

    // Asynchronous reset while in FAULT: takes effect without a clock edge.
    rst_n = 1'b0;
    #2;
    chk_state("async_rst", 0, 32'h0000_0013, 32'h0, 32'h0, 32'd0, 0, 2'd0);
    step();
    rst_n = 1'b1;
    step();
    chk_state("boot2", 0, 32'h0000_0013, 32'h0, 32'h0, 32'd0, 0, 2'd0);

    repeat (32) step();
    chk_state("cap32", 1, 32'hC0DE_001F, 32'h7C, 32'h80, 32'd32, 0, 2'd0);
    step();
    chk_state("range", 0, 32'hC0DE_001F, 32'h7C, 32'h80, 32'd32, 1, 2'd2);
    step();
    chk_state("range_hold", 0, 32'hC0DE_001F, 32'h7C, 32'h80, 32'd32, 1, 2'd2);

    // Out-of-range redirect is accepted; the range fault waits for a non-stalled cycle.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    step();
    redirect_valid  = 1'b0;
    chk_state("oor_redir", 0, 32'h0000_0013, 32'h0, 32'h100, 32'd0, 0, 2'd0);
    stall = 1'b1;
    step();
    chk_state("oor_stall", 0, 32'h0000_0013, 32'h0, 32'h100, 32'd0, 0, 2'd0);
    stall = 1'b0;
    step();
    chk_state("oor_fault", 0, 32'h0000_0013, 32'h0, 32'h100, 32'd0, 1, 2'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
